// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and defaults for the bit-serial adder word driver.
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int SERIAL_ADDER_DEFAULT_W = 8;

endpackage

`default_nettype wire

// File: rtl/lsb_first_shift_reg.sv
// lsb_first_shift_reg: W-bit right-shifting register, usable as PISO (LSB out) or SIPO (MSB in).
`default_nettype none

module lsb_first_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  input  logic         serial_in,
  output logic         serial_out,
  output logic [W-1:0] parallel_out
);

  logic [W-1:0] data_q;
  logic [W-1:0] shifted;

  generate
    if (W == 1) begin : g_single_bit
      assign shifted = serial_in;
    end else begin : g_multi_bit
      assign shifted = {serial_in, data_q[W-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end else if (shift) begin
      data_q <= shifted;
    end
  end

  assign serial_out   = data_q[0];
  assign parallel_out = data_q;

endmodule

`default_nettype wire

// File: rtl/serial_adder_word_driver.sv
// serial_adder_word_driver: streams W-bit operand pairs LSB-first into a bit-serial adder
// and returns the W-bit sum plus carry-out, using one zero flush bit per word.
`default_nettype none

module serial_adder_word_driver
  import serial_adder_pkg::*;
#(
  parameter int W = SERIAL_ADDER_DEFAULT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [W-1:0] s_a,
  input  logic [W-1:0] s_b,
  output logic         ser_a,
  output logic         ser_b,
  input  logic         ser_sum,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [W-1:0] m_sum,
  output logic         m_carry
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             accept;
  logic             shifting;
  logic             flushing;
  logic             carry_q;

  logic [W-1:0]     unused_a_par;
  logic [W-1:0]     unused_b_par;
  logic             unused_sum_lsb;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (s_valid)             state_next = SHIFT;
      SHIFT:   if (bit_cnt == LAST_BIT) state_next = FLUSH;
      FLUSH:                            state_next = HOLD;
      HOLD:    if (m_ready)             state_next = IDLE;
      default:                          state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready  = 1'b0;
    m_valid  = 1'b0;
    shifting = 1'b0;
    flushing = 1'b0;
    case (state)
      IDLE:    s_ready  = 1'b1;
      SHIFT:   shifting = 1'b1;
      FLUSH:   flushing = 1'b1;
      HOLD:    m_valid  = 1'b1;
      default: s_ready  = 1'b0;
    endcase
  end

  assign accept = s_ready & s_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      bit_cnt <= '0;
      carry_q <= 1'b0;
    end else if (shifting) begin
      bit_cnt <= bit_cnt + 1'b1;
    end else if (flushing) begin
      carry_q <= ser_sum;
    end
  end

  // Operand registers shift in zeros, so after W shifts (and in reset) their LSB is 0:
  // ser_a/ser_b come straight from a flop and are already 0 in FLUSH, HOLD and IDLE.
  lsb_first_shift_reg #(.W(W)) u_a_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .shift        (shifting),
    .load_data    (s_a),
    .serial_in    (1'b0),
    .serial_out   (ser_a),
    .parallel_out (unused_a_par)
  );

  lsb_first_shift_reg #(.W(W)) u_b_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .shift        (shifting),
    .load_data    (s_b),
    .serial_in    (1'b0),
    .serial_out   (ser_b),
    .parallel_out (unused_b_par)
  );

  lsb_first_shift_reg #(.W(W)) u_sum_reg (
    .clk          (clk),
    .rst          (rst),
    .load         (accept),
    .shift        (shifting),
    .load_data    ({W{1'b0}}),
    .serial_in    (ser_sum),
    .serial_out   (unused_sum_lsb),
    .parallel_out (m_sum)
  );

  assign m_carry = carry_q;

endmodule

`default_nettype wire
